// File: rtl/gate_exhaustive_tester.sv
// Exhaustive stimulus generator and checker for N-input logic gates.
// It walks every input vector in ascending order, holds each one for HOLD_CYCLES cycles and checks the DUT against a golden gate model.
module gate_exhaustive_tester #(
   parameter int N_INPUTS    = 2,
   parameter int HOLD_CYCLES = 5,
   parameter int ERR_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          gate_mode,
   input  logic                dut_out,
   output logic [N_INPUTS-1:0] stim,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                mode_err,
   output logic [ERR_W-1:0]    err_count,
   output logic [N_INPUTS-1:0] first_fail_vec,
   output logic                first_fail_valid
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_APPLY  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [2:0] M_AND  = 3'd0;
   localparam logic [2:0] M_OR   = 3'd1;
   localparam logic [2:0] M_XOR  = 3'd2;
   localparam logic [2:0] M_NAND = 3'd3;
   localparam logic [2:0] M_NOR  = 3'd4;
   localparam logic [2:0] M_XNOR = 3'd5;

   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [N_INPUTS-1:0] STIM_MAX  = {N_INPUTS{1'b1}};

   logic [1:0]          state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [N_INPUTS-1:0] stim_q, stim_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                merr_q, merr_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [N_INPUTS-1:0] ffv_q, ffv_d;
   logic                ffval_q, ffval_d;

   // Golden model: reserved modes never reach here because they are rejected at start.
   function automatic logic expected_out(input logic [N_INPUTS-1:0] v, input logic [2:0] m);
      logic r;
      case (m)
         M_AND:   r = &v;
         M_OR:    r = |v;
         M_XOR:   r = ^v;
         M_NAND:  r = ~(&v);
         M_NOR:   r = ~(|v);
         M_XNOR:  r = ~(^v);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
      return (e == {ERR_W{1'b1}}) ? e : e + ERR_W'(1);
   endfunction

   function automatic logic mode_valid(input logic [2:0] m);
      return (m <= M_XNOR);
   endfunction

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      hold_d  = hold_q;
      stim_d  = stim_q;
      done_d  = done_q;
      pass_d  = pass_q;
      merr_d  = merr_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffval_d = ffval_q;

      case (state_q)
         S_IDLE, S_FINISH: begin
            if (start) begin
               mode_d  = gate_mode;
               err_d   = '0;
               ffv_d   = '0;
               ffval_d = 1'b0;
               pass_d  = 1'b0;
               stim_d  = '0;
               hold_d  = '0;
               if (mode_valid(gate_mode)) begin
                  state_d = S_APPLY;
                  done_d  = 1'b0;
                  merr_d  = 1'b0;
               end else begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
                  merr_d  = 1'b1;
               end
            end
         end

         S_APPLY: begin
            if (hold_q == HOLD_LAST) begin
               // Sample point: the DUT has had HOLD_CYCLES-1 cycles to settle.
               if (dut_out !== expected_out(stim_q, mode_q)) begin
                  err_d = sat_inc(err_q);
                  if (!ffval_q) begin
                     ffv_d   = stim_q;
                     ffval_d = 1'b1;
                  end
               end
               hold_d = '0;
               if (stim_q != STIM_MAX) begin
                  stim_d = stim_q + N_INPUTS'(1);
               end else begin
                  state_d = S_FINISH;
                  stim_d  = '0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0) & ~merr_q;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         hold_q  <= '0;
         stim_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         merr_q  <= 1'b0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffval_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         hold_q  <= hold_d;
         stim_q  <= stim_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         merr_q  <= merr_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffval_q <= ffval_d;
      end
   end

   assign stim             = stim_q;
   assign busy             = (state_q == S_APPLY);
   assign done             = done_q;
   assign pass             = pass_q;
   assign mode_err         = merr_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffval_q;

endmodule
